// File: rtl/gray_mon.sv
// gray_mon: monitors a 4-bit Gray-coded stream. It decodes each accepted sample to binary,
// classifies the change against the previous accepted sample (repeat / single-bit step / error),
// reports the step direction, counts errors with saturation, and tracks lock via a small FSM.
// Two register stages: the input capture stage, then the decode/compare/output stage.
module gray_mon #(
  parameter int LOCK_CNT = 4,
  parameter int ERRW     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_gray,
  input  logic            in_valid,
  output logic [3:0]      out_bin,
  output logic            out_valid,
  output logic            step,
  output logic            dir_up,
  output logic            step_err,
  output logic [ERRW-1:0] err_cnt,
  output logic            locked
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]      LOCK_CNT_C = 4'(LOCK_CNT);
  localparam logic [ERRW-1:0] ERR_MAX    = {ERRW{1'b1}};

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Number of set bits, used as the Hamming distance between two Gray codes.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  logic [3:0]      s1_gray_q, s1_gray_d;
  logic            s1_valid_q, s1_valid_d;
  logic [3:0]      ref_gray_q, ref_gray_d;
  state_t          state_q, state_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic [3:0]      out_bin_q, out_bin_d;
  logic            out_valid_q, out_valid_d;
  logic            step_q, step_d;
  logic            dir_up_q, dir_up_d;
  logic            step_err_q, step_err_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            locked_q, locked_d;

  logic [3:0]      new_bin_s;
  logic [3:0]      ref_bin_s;
  logic [2:0]      dist_s;
  logic [3:0]      gcnt_inc_s;
  logic            good_s;
  logic            bad_s;

  // Next-state computation for both pipeline stages and the lock FSM.
  always_comb begin
    s1_valid_d  = in_valid;
    s1_gray_d   = s1_gray_q;
    ref_gray_d  = ref_gray_q;
    state_d     = state_q;
    gcnt_d      = gcnt_q;
    out_bin_d   = out_bin_q;
    out_valid_d = 1'b0;
    step_d      = 1'b0;
    dir_up_d    = dir_up_q;
    step_err_d  = 1'b0;
    err_cnt_d   = err_cnt_q;

    new_bin_s  = gray2bin(s1_gray_q);
    ref_bin_s  = gray2bin(ref_gray_q);
    dist_s     = popcount4(s1_gray_q ^ ref_gray_q);
    gcnt_inc_s = gcnt_q + 4'd1;
    good_s     = (dist_s == 3'd1);
    bad_s      = (dist_s >= 3'd2);

    if (in_valid) begin
      s1_gray_d = in_gray;
    end else begin
      s1_gray_d = s1_gray_q;
    end

    if (s1_valid_q) begin
      out_valid_d = 1'b1;
      out_bin_d   = new_bin_s;
      ref_gray_d  = s1_gray_q;
      case (state_q)
        ST_IDLE: begin
          // First sample only establishes the reference.
          state_d = ST_TRACK;
          gcnt_d  = 4'd0;
        end
        ST_TRACK: begin
          if (good_s) begin
            gcnt_d = gcnt_inc_s;
            if (gcnt_inc_s == LOCK_CNT_C) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_TRACK;
            end
          end else if (bad_s) begin
            gcnt_d = 4'd0;
          end else begin
            gcnt_d = gcnt_q;
          end
        end
        ST_LOCKED: begin
          if (bad_s) begin
            state_d = ST_TRACK;
            gcnt_d  = 4'd0;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_IDLE;
          gcnt_d  = 4'd0;
        end
      endcase

      // Step/error flags apply in every state except the reference-loading one.
      if (state_q != ST_IDLE && good_s) begin
        step_d   = 1'b1;
        dir_up_d = (new_bin_s == (ref_bin_s + 4'd1));
      end else if (state_q != ST_IDLE && bad_s) begin
        step_err_d = 1'b1;
        if (err_cnt_q != ERR_MAX) begin
          err_cnt_d = err_cnt_q + {{(ERRW-1){1'b0}}, 1'b1};
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end else begin
        step_d     = 1'b0;
        step_err_d = 1'b0;
      end
    end else begin
      out_valid_d = 1'b0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // All state registers; reset discards in-flight samples and returns the FSM to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_gray_q   <= 4'd0;
      s1_valid_q  <= 1'b0;
      ref_gray_q  <= 4'd0;
      state_q     <= ST_IDLE;
      gcnt_q      <= 4'd0;
      out_bin_q   <= 4'd0;
      out_valid_q <= 1'b0;
      step_q      <= 1'b0;
      dir_up_q    <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= {ERRW{1'b0}};
      locked_q    <= 1'b0;
    end else begin
      s1_gray_q   <= s1_gray_d;
      s1_valid_q  <= s1_valid_d;
      ref_gray_q  <= ref_gray_d;
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      out_bin_q   <= out_bin_d;
      out_valid_q <= out_valid_d;
      step_q      <= step_d;
      dir_up_q    <= dir_up_d;
      step_err_q  <= step_err_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign out_bin   = out_bin_q;
  assign out_valid = out_valid_q;
  assign step      = step_q;
  assign dir_up    = dir_up_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;
  assign locked    = locked_q;

endmodule
